// File: rtl/xsim_bus_rr.sv
// Multi-master / multi-slave bus with registered round-robin arbitration and req/ack handshake.
// Optional access timeout: define XSIM_BUS_TIMEOUT_EN.
module xsim_bus_rr #(
    parameter int MASTERS = 4,
    parameter int SLAVES  = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SEL_W   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [MASTERS-1:0]         m_req_i,
    input  logic [MASTERS-1:0]         m_rw_i,
    input  logic [MASTERS*ADDR_W-1:0]  m_addr_i,
    input  logic [MASTERS*DATA_W-1:0]  m_wdata_i,
    output logic [MASTERS-1:0]         m_ack_o,
    output logic                       m_err_o,
    output logic [DATA_W-1:0]          m_rdata_o,
    output logic [SLAVES-1:0]          s_sel_o,
    output logic                       s_rw_o,
    output logic [ADDR_W-1:0]          s_addr_o,
    output logic [DATA_W-1:0]          s_wdata_o,
    input  logic [SLAVES*DATA_W-1:0]   s_rdata_i,
    input  logic [SLAVES-1:0]          s_ack_i,
    output logic [3:0]                 grant_id_o,
    output logic                       hold_flag_o
);

    // state  | meaning
    // IDLE   | sample requests, pick next owner from rr pointer
    // ACCESS | owner's transfer presented to decoded slave
    // RESP   | one-cycle ack (and err) back to owner
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

    if (MASTERS < 2 || MASTERS > 16 || SLAVES < 2 || SLAVES > 16 || TIMEOUT < 1) begin : g_param_chk
        $error("xsim_bus_rr: parameter out of range");
    end

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_rr_ptr;
    logic                r_err;
    logic                w_err_nxt;

    logic [15:0]         w_req_ext;
    logic                w_found;
    logic [3:0]          w_pick;
    logic [4:0]          w_idx;
    logic                w_m_rw;
    logic [ADDR_W-1:0]   w_m_addr;
    logic [DATA_W-1:0]   w_m_wdata;

    logic [SEL_W-1:0]    w_dec;
    logic [SLAVES-1:0]   w_sel_raw;
    logic [DATA_W-1:0]   w_rdata_sel;
    logic                w_dec_ok;
    logic                w_ack;

    assign w_req_ext = 16'(m_req_i);

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int i = 0; i < MASTERS; i++) begin
            w_idx = {1'b0, r_rr_ptr} + 5'(i);
            if (w_idx >= 5'(MASTERS)) w_idx = w_idx - 5'(MASTERS);
            if (!w_found && w_req_ext[w_idx[3:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[3:0];
            end
        end
    end

    always_comb begin
        w_m_rw    = 1'b0;
        w_m_addr  = '0;
        w_m_wdata = '0;
        for (int m = 0; m < MASTERS; m++) begin
            if (w_pick == 4'(m)) begin
                w_m_rw    = m_rw_i[m];
                w_m_addr  = m_addr_i[m*ADDR_W +: ADDR_W];
                w_m_wdata = m_wdata_i[m*DATA_W +: DATA_W];
            end
        end
    end

    // Decode works off the latched address, so master-side changes cannot move the select.
    assign w_dec = s_addr_o[ADDR_W-1 -: SEL_W];

    always_comb begin
        w_sel_raw   = '0;
        w_rdata_sel = '0;
        for (int s = 0; s < SLAVES; s++) begin
            w_sel_raw[s] = (w_dec == SEL_W'(s));
            if (w_sel_raw[s]) w_rdata_sel = s_rdata_i[s*DATA_W +: DATA_W];
        end
    end

    assign w_dec_ok = |w_sel_raw;
    assign w_ack    = |(s_ack_i & w_sel_raw);

`ifdef XSIM_BUS_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [TO_W-1:0] r_tmo_cnt;
    logic            w_tmo_hit;

    assign w_tmo_hit = (r_tmo_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                     r_tmo_cnt <= '0;
        else if (r_state != ST_ACCESS) r_tmo_cnt <= '0;
        else                          r_tmo_cnt <= r_tmo_cnt + TO_W'(1);
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                // A slave ack wins over an expiring timeout.
                if (w_ack) begin
                    w_state_nxt = ST_RESP;
                end else if (!w_dec_ok) begin
                    w_state_nxt = ST_RESP;
                    w_err_nxt   = 1'b1;
                end
`ifdef XSIM_BUS_TIMEOUT_EN
                else if (w_tmo_hit) begin
                    w_state_nxt = ST_RESP;
                    w_err_nxt   = 1'b1;
                end
`endif
            end
            ST_RESP:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        m_ack_o     = '0;
        m_err_o     = 1'b0;
        s_sel_o     = '0;
        hold_flag_o = 1'b0;
        case (r_state)
            ST_ACCESS: begin
                s_sel_o     = w_sel_raw;
                hold_flag_o = 1'b1;
            end
            ST_RESP: begin
                hold_flag_o = 1'b1;
                m_err_o     = r_err;
                for (int m = 0; m < MASTERS; m++) m_ack_o[m] = (grant_id_o == 4'(m));
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr   <= '0;
            r_err      <= 1'b0;
            grant_id_o <= '0;
            s_rw_o     <= 1'b0;
            s_addr_o   <= '0;
            s_wdata_o  <= '0;
            m_rdata_o  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        grant_id_o <= w_pick;
                        s_rw_o     <= w_m_rw;
                        s_addr_o   <= w_m_addr;
                        s_wdata_o  <= w_m_wdata;
                    end
                end
                ST_ACCESS: begin
                    if (w_state_nxt == ST_RESP) begin
                        r_err     <= w_err_nxt;
                        m_rdata_o <= (w_ack && !s_rw_o) ? w_rdata_sel : '0;
                    end
                end
                ST_RESP: begin
                    r_rr_ptr <= (grant_id_o == 4'(MASTERS - 1)) ? 4'd0 : grant_id_o + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/xsim_bus_rr.md
Name: xsim_bus_rr

Overview:
- Parametrised successor to the fixed 32-slot xSimBus.
- Multi-master, multi-slave bus with registered round-robin arbitration, address-decoded slave select and a request/acknowledge handshake.
- Masters are typically the core instruction port, the core data port and DMA; slaves are ROM, RAM and peripherals.
- Drives hold_flag_o, which the core uses to stall while the bus is busy.

Parameters:
- MASTERS, 4, number of master ports (2..16).
- SLAVES, 4, number of slave ports (2..16).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- SEL_W, 2, number of top address bits used for slave decode; slave index = addr[ADDR_W-1 -: SEL_W].
- TIMEOUT, 255, maximum ACCESS cycles before an error response.

Ports:
- clk  in  1  single clock; all state is updated on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- m_req_i  in  MASTERS  per-master request; held high until that master's ack.
- m_rw_i  in  MASTERS  per-master direction, 1 = write, 0 = read.
- m_addr_i  in  MASTERS*ADDR_W  packed addresses; master m occupies bits [m*ADDR_W +: ADDR_W].
- m_wdata_i  in  MASTERS*DATA_W  packed write data.
- m_ack_o  out  MASTERS  one-cycle completion pulse to the owning master.
- m_err_o  out  1  qualifies m_ack_o: decode error or timeout.
- m_rdata_o  out  DATA_W  registered read data, valid while m_ack_o is high.
- s_sel_o  out  SLAVES  one-hot slave select.
- s_rw_o  out  1  forwarded direction.
- s_addr_o  out  ADDR_W  forwarded address.
- s_wdata_o  out  DATA_W  forwarded write data.
- s_rdata_i  in  SLAVES*DATA_W  packed slave read data.
- s_ack_i  in  SLAVES  slave completion; may be asserted in the same cycle as select.
- grant_id_o  out  4  index of the currently owning master.
- hold_flag_o  out  1  high in ACCESS and RESP.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, rr_ptr = 0, grant_id_o = 0.
  - m_ack_o, m_err_o, m_rdata_o, s_sel_o, s_rw_o, s_addr_o, s_wdata_o and hold_flag_o all 0.
  - Reset asserted mid-transaction aborts it: no ack is issued and the slave select drops immediately.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any m_req_i is high, choose the first requesting index found searching upward from rr_ptr, modulo MASTERS.
  - Register that index into grant_id_o; latch its rw, addr and wdata into the s_* outputs.
  - Go to ACCESS. If no request is pending, stay in IDLE.
- ACCESS:
  - Decoded index d = latched addr[top SEL_W bits].
  - If d < SLAVES: s_sel_o[d] = 1, all other selects 0. If d >= SLAVES: s_sel_o = 0.
  - On s_ack_i[d] = 1: capture s_rdata_i slice d (writes capture 0), set err = 0, go to RESP.
  - If d >= SLAVES: go to RESP on the first ACCESS cycle with err = 1 and rdata = 0.
  - Acks from non-selected slaves are ignored.
- RESP:
  - m_ack_o[grant_id_o] = 1 for exactly one cycle; m_err_o = err; s_sel_o = 0.
  - rr_ptr = (grant_id_o + 1) mod MASTERS; go to IDLE.
  - The master deasserts req in the cycle after it sees ack. A req still high in the following IDLE cycle is treated as a new transaction.
- Latency: with the request seen in IDLE at cycle T and an immediate slave ack, select is high at T+1 and m_ack_o at T+2. Throughput is at most one transaction per 3 cycles.
- Request sampling: only in IDLE. Requests arriving during ACCESS or RESP wait. The latched addr, wdata and rw are immune to master-side changes after grant.
- Fairness: with N continuous requesters, every master is granted within N transactions.
- Simultaneous events: an ack and a timeout expiring in the same cycle resolve as ack (err = 0).

Optional Feature:
- Macro: XSIM_BUS_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter clears on entry to ACCESS and increments each ACCESS cycle.
  - When it reaches TIMEOUT without an ack, go to RESP with err = 1 and rdata = 0. s_sel_o drops the cycle after expiry.
- Undefined: no counter; ACCESS waits indefinitely for the slave ack.

Test Plan:
- Single master read: m_req_i = 0001, m_addr_i[0] = 0x4000_0010, slave 1 acks immediately with 0xDEADBEEF -> s_sel_o = 0010 at T+1; m_ack_o = 0001, m_rdata_o = 0xDEADBEEF, m_err_o = 0 at T+2; hold_flag_o high for exactly 2 cycles.
- Round-robin, all four masters requesting continuously, slaves acking immediately -> grant_id_o sequence 0, 1, 2, 3, 0; each m_ack_o bit pulses once per 12 cycles.
- Decode error with SLAVES = 3: address 0xC000_0000 -> s_sel_o stays 0; m_ack_o pulses with m_err_o = 1 and m_rdata_o = 0, two cycles after the request is sampled.
- Timeout with XSIM_BUS_TIMEOUT_EN and TIMEOUT = 8: slave never acks -> m_err_o = 1 with ack 9 cycles after grant. Without the macro, hold_flag_o remains high for over 100 cycles.
- Write forwarding: master 2 writes 0x1234_5678 to 0x0000_0004, then changes m_wdata_i during ACCESS -> s_wdata_o stays 0x1234_5678 and s_rw_o = 1 until ack.
- Reset mid-ACCESS: assert rst low asynchronously between clock edges -> all outputs are 0 immediately. After release, master 0 is granted first even if master 3 requested previously.
